mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory responder for a stack core: a marker byte arms a store to mem_addr,
// and a host load mode streams bytes into memory while the core is held in reset.
module mem_responder #(
  parameter int         DEPTH  = 32,
  parameter logic [7:0] MARKER = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] mem_addr,
  input  logic [7:0] core_wdata,
  output logic [7:0] data_in,
  input  logic       load_en,
  input  logic       load_valid,
  input  logic [7:0] load_byte,
  output logic       core_reset,
  output logic [7:0] load_addr,
  output logic [7:0] wr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [AW-1:0]   r_loadAddr;
  logic [AW-1:0]   w_nextLoadAddr;
  logic [7:0]      r_wrCount;
  logic            r_exitPulse;
  logic [7:0]      r_mem [DEPTH];

  logic            w_coreWe;
  logic            w_hostWe;
  logic            w_memWe;
  logic [AW-1:0]   w_coreIdx;
  logic [AW-1:0]   w_writeIdx;
  logic [7:0]      w_writeData;

  // Out-of-range core addresses alias onto the implemented words.
  assign w_coreIdx = AW'(int'(mem_addr) % DEPTH);

  always_comb begin
    w_nextState    = r_state;
    w_nextLoadAddr = r_loadAddr;
    w_coreWe       = 1'b0;
    w_hostWe       = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_en) begin
          w_nextState    = LOAD;
          w_nextLoadAddr = '0;
        end else if (core_wdata == MARKER) begin
          w_nextState = ARMED;
        end
      end
      ARMED: begin
        if (load_en) begin
          w_nextState    = LOAD;
          w_nextLoadAddr = '0;
        end else begin
          w_coreWe    = 1'b1;
          w_nextState = IDLE;
        end
      end
      LOAD: begin
        if (!load_en) begin
          w_nextState = IDLE;
        end else if (load_valid) begin
          w_hostWe       = 1'b1;
          w_nextLoadAddr = r_loadAddr + AW'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Reset suppresses both write ports; the array itself is never cleared.
  assign w_memWe     = !reset && (w_coreWe || w_hostWe);
  assign w_writeIdx  = w_hostWe ? r_loadAddr : w_coreIdx;
  assign w_writeData = w_hostWe ? load_byte : core_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_loadAddr  <= '0;
      r_wrCount   <= 8'd0;
      r_exitPulse <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_loadAddr  <= w_nextLoadAddr;
      r_exitPulse <= (r_state == LOAD) && !load_en;
      if (w_coreWe && (r_wrCount != 8'hFF)) begin
        r_wrCount <= r_wrCount + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_memWe) begin
      r_mem[w_writeIdx] <= w_writeData;
    end
  end

  assign data_in    = r_mem[w_coreIdx];
  assign core_reset = reset || (r_state == LOAD) || r_exitPulse;
  assign load_addr  = 8'(r_loadAddr);
  assign wr_count   = r_wrCount;

endmodule
